pe_mul_seq: RTL and testbench

Multi-cycle multiply sequencer for the PE EX stage. It replaces the single-cycle 32x32 combinational multiply with a single shared 16x16 unsigned partial-product multiplier, which it time-multiplexes over several cycles. It accepts one operation at a time from ID/EX, stalls the pipeline while busy, and presents the result and the RF write address to the WB selection logic with a one-cycle done pulse.

---
 rtl/pe_mul_seq_pkg.sv | 34 +++
 rtl/pe_mul_seq_half.sv | 19 +
 rtl/pe_mul_seq.sv | 174 +++++++++++++++++
 tb/tb_pe_mul_seq.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mul_seq_pkg.sv
// Shared constants for the PE multi-cycle multiply sequencer: state encoding,
// state width and result latency. PE_MUL_SEQ_HIGH_EN adds the PP3 high-word state.
package pe_mul_seq_pkg;

  localparam int PE_MULSEQ_STATE_W = 3;

  localparam logic [PE_MULSEQ_STATE_W-1:0] PE_MULSEQ_ST_IDLE = 3'd0;
  localparam logic [PE_MULSEQ_STATE_W-1:0] PE_MULSEQ_ST_PP0  = 3'd1;
  localparam logic [PE_MULSEQ_STATE_W-1:0] PE_MULSEQ_ST_PP1  = 3'd2;
  localparam logic [PE_MULSEQ_STATE_W-1:0] PE_MULSEQ_ST_PP2  = 3'd3;
  localparam logic [PE_MULSEQ_STATE_W-1:0] PE_MULSEQ_ST_PP3  = 3'd4;
  localparam logic [PE_MULSEQ_STATE_W-1:0] PE_MULSEQ_ST_DONE = 3'd5;

  typedef enum logic [PE_MULSEQ_STATE_W-1:0] {
    ST_IDLE = PE_MULSEQ_ST_IDLE,
    ST_PP0  = PE_MULSEQ_ST_PP0,
    ST_PP1  = PE_MULSEQ_ST_PP1,
    ST_PP2  = PE_MULSEQ_ST_PP2,
    ST_PP3  = PE_MULSEQ_ST_PP3,
    ST_DONE = PE_MULSEQ_ST_DONE
  } mulseq_state_e;

`ifdef PE_MUL_SEQ_HIGH_EN
  localparam int PE_MULSEQ_LATENCY = 5;
`else
  localparam int PE_MULSEQ_LATENCY = 4;
`endif

  // Busy covers every partial-product state; IDLE and DONE can accept a new op.
  function automatic logic mulseq_busy(input mulseq_state_e st);
    return (st == ST_PP0) || (st == ST_PP1) || (st == ST_PP2) || (st == ST_PP3);
  endfunction

endpackage

// File: rtl/pe_mul_seq_half.sv
// Combinational HALF x HALF unsigned multiplier with operand isolation; the single
// shared partial-product unit of pe_mul_seq and the swap point for a macro multiplier.
module pe_mul_half #(
  parameter int HALF = 16
) (
  input  logic              en_i,
  input  logic [HALF-1:0]   a_i,
  input  logic [HALF-1:0]   b_i,
  output logic [2*HALF-1:0] p_o
);

  logic [HALF-1:0] a_iso;
  logic [HALF-1:0] b_iso;

  assign a_iso = en_i ? a_i : '0;
  assign b_iso = en_i ? b_i : '0;
  assign p_o   = (2*HALF)'(a_iso) * (2*HALF)'(b_iso);

endmodule

// File: rtl/pe_mul_seq.sv
// Multi-cycle multiply sequencer: low word of A*B from one time-multiplexed HALF x HALF
// multiplier over PP0..PP2. Defining PE_MUL_SEQ_HIGH_EN adds PP3 and oResult_Hi.
module pe_mul_seq
  import pe_mul_seq_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int RF_INDEX_WIDTH = 5
) (
  input  logic                      iClk,
  input  logic                      iReset,
  input  logic                      iStart,
  input  logic                      iFlush,
  input  logic [DATA_WIDTH-1:0]     iOperand_A,
  input  logic [DATA_WIDTH-1:0]     iOperand_B,
  input  logic [RF_INDEX_WIDTH-1:0] iRF_Write_Addr,
  output logic                      oBusy,
  output logic                      oDone,
  output logic [DATA_WIDTH-1:0]     oResult,
`ifdef PE_MUL_SEQ_HIGH_EN
  output logic [DATA_WIDTH-1:0]     oResult_Hi,
`endif
  output logic [RF_INDEX_WIDTH-1:0] oRF_Write_Addr,
  output logic                      oRF_Write_Enable
);

  localparam int HALF = DATA_WIDTH / 2;
`ifdef PE_MUL_SEQ_HIGH_EN
  localparam int ACC_W = 2 * DATA_WIDTH;
`else
  localparam int ACC_W = DATA_WIDTH;
`endif

  mulseq_state_e             state_q;
  logic [DATA_WIDTH-1:0]     a_q;
  logic [DATA_WIDTH-1:0]     b_q;
  logic [RF_INDEX_WIDTH-1:0] addr_q;
  logic [ACC_W-1:0]          acc_q;
  logic [ACC_W-1:0]          acc_d;
  logic [DATA_WIDTH-1:0]     result_q;
  logic                      done_q;
`ifdef PE_MUL_SEQ_HIGH_EN
  logic [DATA_WIDTH-1:0]     result_hi_q;
`endif

  logic                      mul_en;
  logic [HALF-1:0]           mul_a;
  logic [HALF-1:0]           mul_b;
  logic [DATA_WIDTH-1:0]     pp;

  pe_mul_half #(
    .HALF (HALF)
  ) u_mul_half (
    .en_i (mul_en),
    .a_i  (mul_a),
    .b_i  (mul_b),
    .p_o  (pp)
  );

  // Partial-product schedule: operand halves are routed to the multiplier only in
  // PP states and the product is folded into the accumulator at its weight.
  always_comb begin
    mul_en = 1'b0;
    mul_a  = '0;
    mul_b  = '0;
    acc_d  = acc_q;
    case (state_q)
      ST_PP0: begin
        mul_en = 1'b1;
        mul_a  = a_q[HALF-1:0];
        mul_b  = b_q[HALF-1:0];
        acc_d  = ACC_W'(pp);
      end
      ST_PP1: begin
        mul_en = 1'b1;
        mul_a  = a_q[HALF-1:0];
        mul_b  = b_q[DATA_WIDTH-1:HALF];
        acc_d  = acc_q + (ACC_W'(pp) << HALF);
      end
      ST_PP2: begin
        mul_en = 1'b1;
        mul_a  = a_q[DATA_WIDTH-1:HALF];
        mul_b  = b_q[HALF-1:0];
        acc_d  = acc_q + (ACC_W'(pp) << HALF);
      end
`ifdef PE_MUL_SEQ_HIGH_EN
      ST_PP3: begin
        mul_en = 1'b1;
        mul_a  = a_q[DATA_WIDTH-1:HALF];
        mul_b  = b_q[DATA_WIDTH-1:HALF];
        acc_d  = acc_q + (ACC_W'(pp) << DATA_WIDTH);
      end
`endif
      default: begin
        acc_d = acc_q;
      end
    endcase
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      addr_q      <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      done_q      <= 1'b0;
`ifdef PE_MUL_SEQ_HIGH_EN
      result_hi_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      if (iFlush) begin
        // Abort wins over a same-edge start; the result register is left untouched.
        state_q <= ST_IDLE;
      end else begin
        case (state_q)
          ST_IDLE, ST_DONE: begin
            if (iStart) begin
              a_q     <= iOperand_A;
              b_q     <= iOperand_B;
              addr_q  <= iRF_Write_Addr;
              acc_q   <= '0;
              state_q <= ST_PP0;
            end else begin
              state_q <= ST_IDLE;
            end
          end
          ST_PP0: begin
            acc_q   <= acc_d;
            state_q <= ST_PP1;
          end
          ST_PP1: begin
            acc_q   <= acc_d;
            state_q <= ST_PP2;
          end
`ifdef PE_MUL_SEQ_HIGH_EN
          ST_PP2: begin
            acc_q   <= acc_d;
            state_q <= ST_PP3;
          end
          ST_PP3: begin
            acc_q       <= acc_d;
            result_q    <= acc_d[DATA_WIDTH-1:0];
            result_hi_q <= acc_d[ACC_W-1:DATA_WIDTH];
            done_q      <= 1'b1;
            state_q     <= ST_DONE;
          end
`else
          ST_PP2: begin
            acc_q    <= acc_d;
            result_q <= acc_d[DATA_WIDTH-1:0];
            done_q   <= 1'b1;
            state_q  <= ST_DONE;
          end
`endif
          default: begin
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign oBusy            = mulseq_busy(state_q);
  assign oDone            = done_q;
  assign oResult          = result_q;
  assign oRF_Write_Addr   = addr_q;
  assign oRF_Write_Enable = done_q;
`ifdef PE_MUL_SEQ_HIGH_EN
  assign oResult_Hi       = result_hi_q;
`endif

endmodule

// File: tb/tb_pe_mul_seq.sv
// Self-checking bench for pe_mul_seq: table vectors, randomized ops against a 64-bit
// product model, and hand-written back-to-back, flush and async-reset sequences.
module tb_pe_mul_seq;

`ifdef PE_MUL_SEQ_HIGH_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  logic        iClk;
  logic        iReset;
  logic        iStart;
  logic        iFlush;
  logic [31:0] iOperand_A;
  logic [31:0] iOperand_B;
  logic [4:0]  iRF_Write_Addr;
  logic        oBusy;
  logic        oDone;
  logic [31:0] oResult;
`ifdef PE_MUL_SEQ_HIGH_EN
  logic [31:0] oResult_Hi;
`endif
  logic [4:0]  oRF_Write_Addr;
  logic        oRF_Write_Enable;

  pe_mul_seq #(
    .DATA_WIDTH     (32),
    .RF_INDEX_WIDTH (5)
  ) dut (
    .iClk             (iClk),
    .iReset           (iReset),
    .iStart           (iStart),
    .iFlush           (iFlush),
    .iOperand_A       (iOperand_A),
    .iOperand_B       (iOperand_B),
    .iRF_Write_Addr   (iRF_Write_Addr),
    .oBusy            (oBusy),
    .oDone            (oDone),
    .oResult          (oResult),
`ifdef PE_MUL_SEQ_HIGH_EN
    .oResult_Hi       (oResult_Hi),
`endif
    .oRF_Write_Addr   (oRF_Write_Addr),
    .oRF_Write_Enable (oRF_Write_Enable)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  addr;
    logic [63:0] exp;
  } vec_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  logic [31:0] last_lo = '0;
  vec_t        tbl[6];

  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] wa;
    logic [63:0] wb;
    wa = {32'd0, a};
    wb = {32'd0, b};
    return wa * wb;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  // One isolated operation from an idle sequencer; expectations supplied by the caller.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [4:0] addr,
                        input logic [63:0] exp, input string tag);
    int cyc;
    int busy_cnt;
    bit seen;
    iOperand_A     = a;
    iOperand_B     = b;
    iRF_Write_Addr = addr;
    iStart         = 1'b1;
    cyc = 0;
    busy_cnt = 0;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      step();
      cyc++;
      iStart         = 1'b0;
      iOperand_A     = ~a;
      iOperand_B     = ~b;
      iRF_Write_Addr = ~addr;
      if (oDone) seen = 1'b1;
      else if (oBusy) busy_cnt++;
    end
    check({tag, "_latency"}, 64'(cyc), 64'(LAT));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(LAT - 1));
    check({tag, "_result"}, 64'(oResult), 64'(exp[31:0]));
    check({tag, "_addr"}, 64'(oRF_Write_Addr), 64'(addr));
    check({tag, "_wen"}, 64'(oRF_Write_Enable), 64'(1));
`ifdef PE_MUL_SEQ_HIGH_EN
    check({tag, "_result_hi"}, 64'(oResult_Hi), 64'(exp[63:32]));
`endif
    last_lo = exp[31:0];
    step();
    check({tag, "_done_one_cycle"}, 64'(oDone), 64'(0));
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    logic [31:0] a1;
    logic [31:0] b1;
    logic [31:0] a2;
    logic [31:0] b2;
    int cyc;
    bit seen;
    bit bad;

    tbl[0] = '{a: 32'd7,          b: 32'd6,          addr: 5'd3,  exp: 64'h0000_0000_0000_002A};
    tbl[1] = '{a: 32'h0001_2345,  b: 32'h0001_0001,  addr: 5'd12, exp: 64'h0000_0001_2346_2345};
    tbl[2] = '{a: 32'hFFFF_FFFF,  b: 32'hFFFF_FFFF,  addr: 5'd31, exp: 64'hFFFF_FFFE_0000_0001};
    tbl[3] = '{a: 32'h0000_0000,  b: 32'hDEAD_BEEF,  addr: 5'd1,  exp: 64'h0000_0000_0000_0000};
    tbl[4] = '{a: 32'h8000_0000,  b: 32'h0000_0002,  addr: 5'd17, exp: 64'h0000_0001_0000_0000};
    tbl[5] = '{a: 32'h0000_FFFF,  b: 32'h0000_FFFF,  addr: 5'd9,  exp: 64'h0000_0000_FFFE_0001};

    iReset = 1'b1;
    iStart = 1'b0;
    iFlush = 1'b0;
    iOperand_A = '0;
    iOperand_B = '0;
    iRF_Write_Addr = '0;
    #12;
    check("reset_busy", 64'(oBusy), 64'(0));
    check("reset_done", 64'(oDone), 64'(0));
    check("reset_result", 64'(oResult), 64'(0));
    check("reset_addr", 64'(oRF_Write_Addr), 64'(0));
`ifdef PE_MUL_SEQ_HIGH_EN
    check("reset_result_hi", 64'(oResult_Hi), 64'(0));
`endif
    iReset = 1'b0;
    step();

    for (int i = 0; i < 6; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].addr, tbl[i].exp, $sformatf("vec%0d", i));
    end

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      if (i % 5 == 0) ra = {16'hFFFF, ra[15:0]};
      run_op(ra, rb, 5'($urandom_range(0, 31)), ref_mul(ra, rb), $sformatf("rnd%0d", i));
    end

    // Back to back: start held through busy, new operands raised in the DONE cycle.
    a1 = 32'h0000_1234;
    b1 = 32'h0000_5678;
    a2 = 32'hDEAD_BEEF;
    b2 = 32'h0003_0007;
    iOperand_A = a1;
    iOperand_B = b1;
    iRF_Write_Addr = 5'd4;
    iStart = 1'b1;
    cyc = 0;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      step();
      cyc++;
      if (oDone) seen = 1'b1;
    end
    check("b2b_first_latency", 64'(cyc), 64'(LAT));
    check("b2b_first_result", 64'(oResult), 64'(ref_mul(a1, b1) & 64'hFFFF_FFFF));
    check("b2b_first_addr", 64'(oRF_Write_Addr), 64'(4));
    iOperand_A = a2;
    iOperand_B = b2;
    iRF_Write_Addr = 5'd21;
    step();
    iStart = 1'b0;
    check("b2b_no_bubble_busy", 64'(oBusy), 64'(1));
    check("b2b_first_pulse_once", 64'(oDone), 64'(0));
    cyc = 1;
    seen = 1'b0;
    while (cyc < 20 && !seen) begin
      step();
      cyc++;
      if (oDone) seen = 1'b1;
    end
    check("b2b_done_spacing", 64'(cyc), 64'(LAT));
    check("b2b_second_result", 64'(oResult), 64'(ref_mul(a2, b2) & 64'hFFFF_FFFF));
    check("b2b_second_addr", 64'(oRF_Write_Addr), 64'(21));
`ifdef PE_MUL_SEQ_HIGH_EN
    check("b2b_second_result_hi", 64'(oResult_Hi), 64'(ref_mul(a2, b2) >> 32));
`endif
    last_lo = ref_mul(a2, b2) & 64'hFFFF_FFFF;
    step();
    check("b2b_idle_after", 64'(oBusy), 64'(0));

    // Flush in PP2 together with a new start request.
    iOperand_A = 32'h1111_1111;
    iOperand_B = 32'h0000_0003;
    iRF_Write_Addr = 5'd6;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step();
    step();
    check("flush_pre_busy", 64'(oBusy), 64'(1));
    iFlush = 1'b1;
    iStart = 1'b1;
    iOperand_A = 32'd5;
    iOperand_B = 32'd5;
    step();
    iFlush = 1'b0;
    iStart = 1'b0;
    check("flush_busy", 64'(oBusy), 64'(0));
    check("flush_done", 64'(oDone), 64'(0));
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (oDone || oBusy) bad = 1'b1;
    end
    check("flush_no_done_no_accept", 64'(bad), 64'(0));
    check("flush_result_held", 64'(oResult), 64'(last_lo));

    // Asynchronous reset pulse between edges while in PP1.
    iOperand_A = 32'h0BAD_F00D;
    iOperand_B = 32'h0000_0101;
    iRF_Write_Addr = 5'd9;
    iStart = 1'b1;
    step();
    iStart = 1'b0;
    step();
    check("rst_mid_pre_busy", 64'(oBusy), 64'(1));
    #2 iReset = 1'b1;
    #1;
    check("rst_mid_busy", 64'(oBusy), 64'(0));
    check("rst_mid_done", 64'(oDone), 64'(0));
    check("rst_mid_result", 64'(oResult), 64'(0));
    check("rst_mid_addr", 64'(oRF_Write_Addr), 64'(0));
    #1 iReset = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (oDone || oBusy) bad = 1'b1;
    end
    check("rst_mid_no_done_after", 64'(bad), 64'(0));
    run_op(32'd7, 32'd6, 5'd3, 64'h2A, "post_reset");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
